// File: rtl/stopwatch_lap_ctrl.sv
// Lap-record controller: captures laps into the 30-entry lap memory, clears it, and reviews laps oldest-first.
// Build option LAP_WRAP_EN: ring-buffer overwrite when full; undefined, laps are dropped when full.
module stopwatch_lap_ctrl #(
    parameter int DEPTH = 30,
    parameter int AW    = 5,
    parameter int DW    = 28
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iRunning,
    input  logic [DW-1:0] iTime,
    input  logic          iLapPulse,
    input  logic          iClearPulse,
    input  logic          iReviewPulse,
    input  logic          iNextPulse,
    input  logic          iPrevPulse,
    output logic          oMemWE,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemWData,
    input  logic [DW-1:0] iMemRData,
    output logic [AW-1:0] oLapCount,
    output logic          oFull,
    output logic          oReviewMode,
    output logic [AW-1:0] oReviewIdx,
    output logic [DW-1:0] oReviewData,
    output logic          oLapDrop,
    output logic          oBusy
);
    typedef enum logic [1:0] {
        ST_REC    = 2'd0,
        ST_WRITE  = 2'd1,
        ST_REVIEW = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE  = AW'(32'sd1);
    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 32'sd1);
    localparam logic [AW-1:0] A_FULL = AW'(DEPTH);

    state_t        state_r, state_s;
    logic [AW-1:0] wptr_r, wptr_s, count_r, count_s, ridx_r, ridx_s, clr_r, clr_s;
    logic [DW-1:0] data_r, data_s;
    logic          drop_s;
    logic          mem_we_r, mem_we_s, busy_r, busy_s, mode_r, mode_s, full_r, drop_r;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s, rdata_r;

    // Once full, the oldest lap sits at the write pointer; otherwise at address 0.
    function automatic logic [AW-1:0] phys_addr(input logic [AW-1:0] idx,
                                                input logic [AW-1:0] wptr,
                                                input logic [AW-1:0] cnt);
        logic [AW:0] sum;
        if (cnt == A_FULL) begin
            sum = {1'b0, wptr} + {1'b0, idx};
        end else begin
            sum = {1'b0, idx};
        end
        if (sum >= {1'b0, A_FULL}) begin
            phys_addr = AW'(sum - {1'b0, A_FULL});
        end else begin
            phys_addr = sum[AW-1:0];
        end
    endfunction

    // State and bookkeeping registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= ST_REC;
            wptr_r  <= A_ZERO;
            count_r <= A_ZERO;
            ridx_r  <= A_ZERO;
            clr_r   <= A_ZERO;
            data_r  <= {DW{1'b0}};
        end else begin
            state_r <= state_s;
            wptr_r  <= wptr_s;
            count_r <= count_s;
            ridx_r  <= ridx_s;
            clr_r   <= clr_s;
            data_r  <= data_s;
        end
    end

    // Next-state logic; request priority is clear > review toggle > lap > navigation
    always_comb begin
        state_s = state_r;
        wptr_s  = wptr_r;
        count_s = count_r;
        ridx_s  = ridx_r;
        clr_s   = clr_r;
        data_s  = data_r;
        drop_s  = 1'b0;
        case (state_r)
            ST_REC: begin
                if (iClearPulse) begin
                    state_s = ST_CLEAR;
                    clr_s   = A_ZERO;
                end else if (iReviewPulse) begin
                    if (count_r != A_ZERO) begin
                        state_s = ST_REVIEW;
                        ridx_s  = count_r - A_ONE;
                    end else begin
                        state_s = ST_REC;
                    end
                end else if (iLapPulse && iRunning) begin
`ifdef LAP_WRAP_EN
                    state_s = ST_WRITE;
                    data_s  = iTime;
`else
                    if (count_r == A_FULL) begin
                        drop_s = 1'b1;
                    end else begin
                        state_s = ST_WRITE;
                        data_s  = iTime;
                    end
`endif
                end else begin
                    state_s = ST_REC;
                end
            end
            ST_WRITE: begin
                state_s = ST_REC;
                wptr_s  = (wptr_r == A_LAST) ? A_ZERO : wptr_r + A_ONE;
                count_s = (count_r == A_FULL) ? count_r : count_r + A_ONE;
            end
            ST_REVIEW: begin
                if (iClearPulse) begin
                    state_s = ST_CLEAR;
                    clr_s   = A_ZERO;
                end else if (iReviewPulse) begin
                    state_s = ST_REC;
                end else if (iNextPulse && !iPrevPulse) begin
                    if (ridx_r < count_r - A_ONE) begin
                        ridx_s = ridx_r + A_ONE;
                    end else begin
                        ridx_s = ridx_r;
                    end
                end else if (iPrevPulse && !iNextPulse) begin
                    if (ridx_r != A_ZERO) begin
                        ridx_s = ridx_r - A_ONE;
                    end else begin
                        ridx_s = ridx_r;
                    end
                end else begin
                    state_s = ST_REVIEW;
                end
            end
            ST_CLEAR: begin
                if (clr_r == A_LAST) begin
                    state_s = ST_REC;
                    clr_s   = A_ZERO;
                    count_s = A_ZERO;
                    wptr_s  = A_ZERO;
                    ridx_s  = A_ZERO;
                end else begin
                    clr_s = clr_r + A_ONE;
                end
            end
            default: begin
                state_s = ST_REC;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a register
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = A_ZERO;
        mem_wdata_s = {DW{1'b0}};
        busy_s      = 1'b0;
        mode_s      = 1'b0;
        case (state_s)
            ST_WRITE: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = wptr_s;
                mem_wdata_s = data_s;
                busy_s      = 1'b1;
            end
            ST_CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = clr_s;
                busy_s     = 1'b1;
            end
            ST_REVIEW: begin
                mem_addr_s = phys_addr(ridx_s, wptr_s, count_s);
                mode_s     = 1'b1;
            end
            ST_REC: begin
                mem_addr_s = A_ZERO;
            end
            default: begin
                mem_addr_s = A_ZERO;
            end
        endcase
    end

    // Output registers; review data follows the asynchronous memory read while reviewing
    always_ff @(posedge iClk) begin
        if (iRst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= A_ZERO;
            mem_wdata_r <= {DW{1'b0}};
            busy_r      <= 1'b0;
            mode_r      <= 1'b0;
            full_r      <= 1'b0;
            drop_r      <= 1'b0;
            rdata_r     <= {DW{1'b0}};
        end else begin
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
            mode_r      <= mode_s;
            full_r      <= (count_s == A_FULL);
            drop_r      <= drop_s;
            rdata_r     <= (state_r == ST_REVIEW) ? iMemRData : rdata_r;
        end
    end

    assign oMemWE      = mem_we_r;
    assign oMemAddr    = mem_addr_r;
    assign oMemWData   = mem_wdata_r;
    assign oLapCount   = count_r;
    assign oFull       = full_r;
    assign oReviewMode = mode_r;
    assign oReviewIdx  = ridx_r;
    assign oReviewData = rdata_r;
    assign oLapDrop    = drop_r;
    assign oBusy       = busy_r;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with a behavioural lap memory (async read, sync write).
module tb_stopwatch_lap_ctrl;
    localparam int DEPTH = 30;
    localparam int AW    = 5;
    localparam int DW    = 28;

    logic          iClk = 1'b0;
    logic          iRst, iRunning, iLapPulse, iClearPulse, iReviewPulse, iNextPulse, iPrevPulse;
    logic [DW-1:0] iTime, iMemRData;
    logic          oMemWE, oFull, oReviewMode, oLapDrop, oBusy;
    logic [AW-1:0] oMemAddr, oLapCount, oReviewIdx;
    logic [DW-1:0] oMemWData, oReviewData;

    logic [DW-1:0] mem [DEPTH];
    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int base, nclr, nz;

    stopwatch_lap_ctrl dut (
        .iClk(iClk), .iRst(iRst), .iRunning(iRunning), .iTime(iTime),
        .iLapPulse(iLapPulse), .iClearPulse(iClearPulse), .iReviewPulse(iReviewPulse),
        .iNextPulse(iNextPulse), .iPrevPulse(iPrevPulse),
        .oMemWE(oMemWE), .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData),
        .oLapCount(oLapCount), .oFull(oFull), .oReviewMode(oReviewMode), .oReviewIdx(oReviewIdx),
        .oReviewData(oReviewData), .oLapDrop(oLapDrop), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    assign iMemRData = (oMemAddr < AW'(DEPTH)) ? mem[oMemAddr] : {DW{1'b0}};

    always @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {DW{1'b0}};
        end else if (oMemWE) begin
            mem[oMemAddr] <= oMemWData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({oMemWE, oMemAddr, oFull, oReviewMode, oReviewIdx, oLapDrop, oBusy, oLapCount}), 32'd0);
        chk({tag, "_wdata"}, 32'(oMemWData), 32'd0);
        chk({tag, "_rdata"}, 32'(oReviewData), 32'd0);
    endtask

    task automatic do_lap(input int t, input int exp_addr, input int exp_cnt);
        iTime = DW'(t); iRunning = 1'b1; iLapPulse = 1'b1;
        tick();
        iLapPulse = 1'b0;
        chk("lap_we", 32'(oMemWE), 32'd1);
        chk("lap_addr", 32'(oMemAddr), exp_addr);
        chk("lap_wdata", 32'(oMemWData), t);
        tick();
        chk("lap_cnt", 32'(oLapCount), exp_cnt);
    endtask

    task automatic nav(input logic nx, input logic pv, input int exp_idx, input int exp_data);
        iNextPulse = nx; iPrevPulse = pv;
        tick();
        iNextPulse = 1'b0; iPrevPulse = 1'b0;
        chk("nav_idx", 32'(oReviewIdx), exp_idx);
        tick();
        chk("nav_data", 32'(oReviewData), exp_data);
    endtask

    initial begin
        iRst = 1'b1; iRunning = 1'b0; iLapPulse = 1'b0; iClearPulse = 1'b0;
        iReviewPulse = 1'b0; iNextPulse = 1'b0; iPrevPulse = 1'b0; iTime = {DW{1'b0}};
        repeat (3) tick();
        chk_all_zero("reset");
        iRst = 1'b0;
        tick();

        // three laps, then review navigation
        do_lap(100, 0, 1);
        do_lap(200, 1, 2);
        do_lap(300, 2, 3);
        iReviewPulse = 1'b1; tick(); iReviewPulse = 1'b0;
        chk("rev_mode", 32'(oReviewMode), 32'd1);
        chk("rev_idx", 32'(oReviewIdx), 32'd2);
        tick();
        chk("rev_data", 32'(oReviewData), 32'd300);
        nav(1'b0, 1'b1, 1, 200);
        nav(1'b0, 1'b1, 0, 100);
        nav(1'b0, 1'b1, 0, 100);
        nav(1'b1, 1'b1, 0, 100);
        nav(1'b1, 1'b0, 1, 200);
        iRunning = 1'b1; iLapPulse = 1'b1; tick(); iLapPulse = 1'b0;
        chk("rev_lap_we", 32'(oMemWE), 32'd0);
        tick();
        chk("rev_lap_cnt", 32'(oLapCount), 32'd3);
        iReviewPulse = 1'b1; tick(); iReviewPulse = 1'b0;
        chk("rec_mode", 32'(oReviewMode), 32'd0);
        chk("rec_addr", 32'(oMemAddr), 32'd0);

        // lap while stopped is ignored
        iRunning = 1'b0; iLapPulse = 1'b1; tick(); iLapPulse = 1'b0;
        chk("stop_we", 32'(oMemWE), 32'd0);
        chk("stop_busy", 32'(oBusy), 32'd0);
        tick();
        chk("stop_cnt", 32'(oLapCount), 32'd3);

        // clear with five entries, lap injected mid-clear
        do_lap(400, 3, 4);
        do_lap(500, 4, 5);
        base = wr_cnt;
        iClearPulse = 1'b1; tick(); iClearPulse = 1'b0;
        nclr = 0;
        while (oBusy && nclr < 40) begin
            chk("clr_we", 32'(oMemWE), 32'd1);
            chk("clr_addr", 32'(oMemAddr), nclr);
            chk("clr_wdata", 32'(oMemWData), 32'd0);
            iRunning = 1'b1;
            iLapPulse = (nclr == 10);
            nclr++;
            tick();
        end
        iLapPulse = 1'b0;
        chk("clr_cycles", nclr, 32'd30);
        chk("clr_writes", wr_cnt - base, 32'd30);
        chk("clr_cnt", 32'(oLapCount), 32'd0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != {DW{1'b0}}) nz++;
        chk("clr_mem", nz, 32'd0);
        tick();
        chk("clr_no_late_write", wr_cnt - base, 32'd30);

        // review toggle with empty memory is ignored
        iReviewPulse = 1'b1; tick(); iReviewPulse = 1'b0;
        chk("empty_rev_mode", 32'(oReviewMode), 32'd0);
        chk("empty_rev_we", 32'(oMemWE), 32'd0);

        // fill to 30, then a 31st lap
        for (int k = 1; k <= DEPTH; k++) do_lap(1000 + k, k - 1, k);
        chk("full_flag", 32'(oFull), 32'd1);
`ifdef LAP_WRAP_EN
        do_lap(1031, 0, 30);
        chk("wrap_drop", 32'(oLapDrop), 32'd0);
        iReviewPulse = 1'b1; tick(); iReviewPulse = 1'b0;
        chk("wrap_rev_idx", 32'(oReviewIdx), 32'd29);
        tick();
        chk("wrap_newest", 32'(oReviewData), 32'd1031);
        iPrevPulse = 1'b1; repeat (29) tick(); iPrevPulse = 1'b0;
        chk("wrap_idx0", 32'(oReviewIdx), 32'd0);
        tick();
        chk("wrap_oldest", 32'(oReviewData), 32'd1002);
`else
        base = wr_cnt;
        iTime = DW'(1031); iLapPulse = 1'b1; tick(); iLapPulse = 1'b0;
        chk("drop_pulse", 32'(oLapDrop), 32'd1);
        chk("drop_we", 32'(oMemWE), 32'd0);
        tick();
        chk("drop_pulse_end", 32'(oLapDrop), 32'd0);
        chk("drop_writes", wr_cnt - base, 32'd0);
        chk("drop_cnt", 32'(oLapCount), 32'd30);
        chk("drop_mem29", 32'(mem[29]), 32'd1030);
        iReviewPulse = 1'b1; tick(); iReviewPulse = 1'b0;
        chk("full_rev_idx", 32'(oReviewIdx), 32'd29);
        tick();
        chk("full_newest", 32'(oReviewData), 32'd1030);
        iPrevPulse = 1'b1; repeat (29) tick(); iPrevPulse = 1'b0;
        chk("full_idx0", 32'(oReviewIdx), 32'd0);
        tick();
        chk("full_oldest", 32'(oReviewData), 32'd1001);
`endif

        // clear entered from review, aborted by reset
        iClearPulse = 1'b1; tick(); iClearPulse = 1'b0;
        repeat (10) tick();
        chk("abort_busy", 32'(oBusy), 32'd1);
        iRst = 1'b1; tick();
        chk_all_zero("abort");
        iRst = 1'b0; tick();
        chk("abort_cnt", 32'(oLapCount), 32'd0);
        chk("abort_idle", 32'(oBusy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Lap-record controller for the stopwatch. It captures the running time on each lap press, writes it into the 30-entry lap memory, maintains the write pointer and entry count, clears the memory on request, and provides a review mode that reads stored laps back in chronological order for display. It sits between the stopwatch time counter / button conditioning and the lap memory, whose write port it drives and whose asynchronous read data it consumes.

## Interface
- DEPTH, 30, number of lap entries
- AW, 5, address width
- DW, 28, lap word width, packed {Hour, Min, Sec, Centi}

- iClk  in  1  system clock
- iRst  in  1  synchronous, active-high reset
- iRunning  in  1  stopwatch counting; laps are accepted only when high
- iTime  in  DW  current stopwatch time
- iLapPulse  in  1  single-cycle lap request
- iClearPulse  in  1  single-cycle clear-all request
- iReviewPulse  in  1  single-cycle toggle between record and review
- iNextPulse / iPrevPulse  in  1  single-cycle review navigation
- oMemWE  out  1  memory write enable
- oMemAddr  out  AW  memory address, used for both write and read
- oMemWData  out  DW  memory write data
- iMemRData  in  DW  memory read data, asynchronous read of oMemAddr
- oLapCount  out  AW  stored entries, 0..30
- oFull  out  1  oLapCount == 30
- oReviewMode  out  1  in REVIEW state
- oReviewIdx  out  AW  logical review index, where 0 is the oldest entry
- oReviewData  out  DW  registered lap word at oReviewIdx
- oLapDrop  out  1  one-cycle pulse when a lap is discarded because memory is full (no-wrap build only)
- oBusy  out  1  in WRITE or CLEAR state

## Operation
- States: REC, WRITE, REVIEW, CLEAR.
- Reset:
  - state REC; write pointer, count, review index, and clear counter all 0.
  - Every output is 0.
- Request priority within a cycle: clear > review toggle > lap > navigation.
- REC state:
  - A lap request with iRunning=1 captures iTime into the data register and moves to WRITE.
  - A lap request with iRunning=0 is ignored.
  - A review toggle moves to REVIEW only when count > 0; the review index is set to count-1 (the newest entry).
- WRITE state (one cycle):
  - oMemWE=1, oMemAddr=write pointer, oMemWData=captured time.
  - The write pointer then increments, wrapping from 29 to 0.
  - Count increments and saturates at 30.
  - Returns to REC.
- Full handling: see Configuration.
- REVIEW state:
  - Physical address = (oldest + oReviewIdx) mod 30, where oldest is the write pointer when full and 0 otherwise.
  - oMemAddr carries this address. oReviewData <= iMemRData on every cycle in this state.
  - Next saturates at count-1. Prev saturates at 0. Next and prev in the same cycle leave the index unchanged.
  - A review toggle returns to REC. Lap requests are ignored in this state.
- CLEAR state:
  - Entered from REC or REVIEW on a clear request.
  - Writes 0 to addresses 0..29, one address per cycle, with oMemWE=1.
  - On exit, count=0, write pointer=0, review index=0, state REC.
- All requests except reset are ignored during WRITE and CLEAR.
- When not writing: oMemWE=0 and oMemWData=0. In REC, oMemAddr=0.
- A reset during WRITE or CLEAR aborts immediately. Memory contents already written are not restored; the controller treats memory as empty (count 0).

## Timing
- Lap to memory write: the lap request is sampled in cycle N, the write occurs in cycle N+1, and oLapCount updates at N+2.
- Two consecutive cycles of lap requests: the second request lands in WRITE and is dropped.
- Clear: 30 write cycles following the request cycle; oLapCount=0 in the cycle after the last write.
- Review read: oReviewData is valid 1 cycle after an index change or after entering REVIEW.
- oLapDrop: asserted in the cycle after the dropped request.

## Configuration
- LAP_WRAP_EN defined: ring-buffer mode.
  - When full, a lap overwrites the oldest entry.
  - The write pointer advances, count stays 30, and oldest moves forward by one.
  - oLapDrop is tied to 0.
- LAP_WRAP_EN undefined: stop-when-full mode.
  - When count=30, a lap stays in REC with no write and pulses oLapDrop.

## Test plan
- Reset, then 3 laps with iTime=100, 200, 300 -> writes to addresses 0, 1, 2; oLapCount=3.
- Enter review -> oReviewIdx=2 and oReviewData=300. Prev twice -> 100. Prev again -> stays at index 0. Next and prev in the same cycle -> no change.
- 31 laps, wrap build -> the 31st lap writes address 0; oLapCount=30; review index 0 reads entry 2's time.
- 31 laps, no-wrap build -> no write on the 31st; oLapDrop is high for 1 cycle; address 29 holds the 30th lap.
- Clear with 5 entries -> exactly 30 writes of 0 to addresses 0..29, oBusy high for those cycles, then oLapCount=0. A lap mid-clear is ignored. Assert iRst mid-clear -> all outputs 0 on the next cycle.
- Lap with iRunning=0, or a review toggle with count=0 -> no state change and no write.
